// File: rtl/ds_frame_parser_pkg.sv
// rtl/ds_frame_parser_pkg.sv - shared downstream constants, header layout and FSM encoding
package ds_frame_parser_pkg;

    localparam logic [15:0] DEF_SYNC_WORD = 16'hEB90;

    localparam int WORD_W = 32;
    localparam int BEAT_W = 128;

    localparam int SYNC_MSB   = 31;
    localparam int SYNC_LSB   = 16;
    localparam int DES_ID_MSB = 15;
    localparam int DES_ID_LSB = 8;
    localparam int LEN_MSB    = 7;
    localparam int LEN_LSB    = 0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

    typedef struct packed {
        logic [15:0] sync;
        logic [7:0]  des_id;
        logic [7:0]  len;
    } ds_hdr_t;

    // Split a header word into its fields
    function automatic ds_hdr_t split_hdr(input logic [WORD_W-1:0] w);
        ds_hdr_t h;
        h.sync   = w[SYNC_MSB:SYNC_LSB];
        h.des_id = w[DES_ID_MSB:DES_ID_LSB];
        h.len    = w[LEN_MSB:LEN_LSB];
        return h;
    endfunction

endpackage

// File: rtl/ds_frame_parser_if.sv
// rtl/ds_frame_parser_if.sv - word stream in, burst beats and error status out
interface ds_frame_parser_if #(
    parameter int ERR_CNT_W = 16
) ();
    logic                 ds_word_valid_i;
    logic                 ds_word_sop_i;
    logic                 ds_word_eop_i;
    logic [31:0]          ds_word_data_i;
    logic [7:0]           prased_des_id_o;
    logic                 ds_burst_valid_o;
    logic [127:0]         ds_burst_data_o;
    logic                 ds_burst_sop_o;
    logic                 ds_burst_eop_o;
    logic                 frame_err_o;
    logic [ERR_CNT_W-1:0] frame_err_cnt_o;

    modport master (
        output ds_word_valid_i, ds_word_sop_i, ds_word_eop_i, ds_word_data_i,
        input  prased_des_id_o, ds_burst_valid_o, ds_burst_data_o, ds_burst_sop_o,
        input  ds_burst_eop_o, frame_err_o, frame_err_cnt_o
    );

    modport slave (
        input  ds_word_valid_i, ds_word_sop_i, ds_word_eop_i, ds_word_data_i,
        output prased_des_id_o, ds_burst_valid_o, ds_burst_data_o, ds_burst_sop_o,
        output ds_burst_eop_o, frame_err_o, frame_err_cnt_o
    );
endinterface

// File: rtl/ds_word_packer.sv
// rtl/ds_word_packer.sv - 4x32 to 128 shift/pack register with word index and flush
module ds_word_packer
    import ds_frame_parser_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              flush,
    input  logic [WORD_W-1:0] word,
    output logic              beat_done,
    output logic [BEAT_W-1:0] beat_data
);
    logic [BEAT_W-1:0] pack_q, pack_d;
    logic [1:0]        idx_q, idx_d;

    // Oldest word ends up in the top lane; the index wraps to 0 after the 4th word
    always_comb begin
        beat_data = {pack_q[BEAT_W-WORD_W-1:0], word};
        beat_done = shift_en && (idx_q == 2'd3);
        pack_d    = pack_q;
        idx_d     = idx_q;
        if (flush) begin
            pack_d = '0;
            idx_d  = 2'd0;
        end else if (shift_en) begin
            pack_d = beat_data;
            idx_d  = idx_q + 2'd1;
        end
    end

    // Pack register and word index
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q <= '0;
            idx_q  <= 2'd0;
        end else begin
            pack_q <= pack_d;
            idx_q  <= idx_d;
        end
    end
endmodule

// File: rtl/ds_frame_parser.sv
// rtl/ds_frame_parser.sv - header check, des_id extraction, beat packing and error counting
module ds_frame_parser
    import ds_frame_parser_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter int          ERR_CNT_W = 16
) (
    input logic          sys_clk_i,
    input logic          rst_i,
    ds_frame_parser_if.slave ds_if
);
    logic [1:0]           state_q, state_d;
    logic [7:0]           beat_rem_q, beat_rem_d;
    logic                 first_q, first_d;
    logic [7:0]           des_id_q, des_id_d;
    logic                 bvalid_q, bvalid_d;
    logic [BEAT_W-1:0]    bdata_q, bdata_d;
    logic                 bsop_q, bsop_d;
    logic                 beop_q, beop_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    logic                 shift_en, flush, beat_done, hdr_ok, eop;
    logic [BEAT_W-1:0]    beat_data;
    ds_hdr_t              hdr;

    ds_word_packer u_packer (
        .clk       (sys_clk_i),
        .rst       (rst_i),
        .shift_en  (shift_en),
        .flush     (flush),
        .word      (ds_if.ds_word_data_i),
        .beat_done (beat_done),
        .beat_data (beat_data)
    );

    // Frame FSM: a sop word is always treated as a header, regardless of state
    always_comb begin
        hdr        = split_hdr(ds_if.ds_word_data_i);
        eop        = ds_if.ds_word_eop_i;
        hdr_ok     = (hdr.sync == SYNC_WORD) && (hdr.len != 8'd0) && !eop;
        state_d    = state_q;
        beat_rem_d = beat_rem_q;
        first_d    = first_q;
        des_id_d   = des_id_q;
        bvalid_d   = 1'b0;
        bdata_d    = bdata_q;
        bsop_d     = 1'b0;
        beop_d     = 1'b0;
        err_d      = 1'b0;
        shift_en   = 1'b0;
        flush      = 1'b0;
        if (ds_if.ds_word_valid_i) begin
            if (ds_if.ds_word_sop_i) begin
                flush = 1'b1;
                if (hdr_ok) begin
                    state_d    = ST_PAYLOAD;
                    des_id_d   = hdr.des_id;
                    beat_rem_d = hdr.len;
                    first_d    = 1'b1;
                    // Aborting a frame in flight is an error; a bad header on top is still one pulse
                    err_d      = (state_q == ST_PAYLOAD);
                end else begin
                    err_d   = 1'b1;
                    state_d = eop ? ST_IDLE : ST_DROP;
                end
            end else begin
                case (state_q)
                    ST_PAYLOAD: begin
                        shift_en = 1'b1;
                        if (beat_done) begin
                            bvalid_d   = 1'b1;
                            bdata_d    = beat_data;
                            bsop_d     = first_q;
                            first_d    = 1'b0;
                            beat_rem_d = beat_rem_q - 8'd1;
                            if (beat_rem_q == 8'd1) begin
                                beop_d = 1'b1;
                                if (eop) begin
                                    state_d = ST_IDLE;
                                end else begin
                                    err_d   = 1'b1;
                                    state_d = ST_DROP;
                                end
                            end else if (eop) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end else if (eop) begin
                            // Partial beat is thrown away, never emitted
                            err_d   = 1'b1;
                            flush   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (eop) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
        cnt_d = (err_d && (cnt_q != '1)) ? cnt_q + ERR_CNT_W'(1) : cnt_q;
    end

    // State, frame bookkeeping and output registers
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            beat_rem_q <= 8'd0;
            first_q    <= 1'b0;
            des_id_q   <= 8'd0;
            bvalid_q   <= 1'b0;
            bdata_q    <= '0;
            bsop_q     <= 1'b0;
            beop_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_rem_q <= beat_rem_d;
            first_q    <= first_d;
            des_id_q   <= des_id_d;
            bvalid_q   <= bvalid_d;
            bdata_q    <= bdata_d;
            bsop_q     <= bsop_d;
            beop_q     <= beop_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ds_if.prased_des_id_o  = des_id_q;
    assign ds_if.ds_burst_valid_o = bvalid_q;
    assign ds_if.ds_burst_data_o  = bdata_q;
    assign ds_if.ds_burst_sop_o   = bsop_q;
    assign ds_if.ds_burst_eop_o   = beop_q;
    assign ds_if.frame_err_o      = err_q;
    assign ds_if.frame_err_cnt_o  = cnt_q;
endmodule

// File: tb/tb_ds_frame_parser.sv
// tb/tb_ds_frame_parser.sv - table-driven checks of ds_frame_parser plus counter saturation
module tb_ds_frame_parser;

    logic clk;
    logic rst;

    ds_frame_parser_if #(.ERR_CNT_W(16)) ifc ();
    ds_frame_parser_if #(.ERR_CNT_W(2))  ifc2 ();

    ds_frame_parser #(.SYNC_WORD(16'hEB90), .ERR_CNT_W(16)) dut (
        .sys_clk_i (clk),
        .rst_i     (rst),
        .ds_if     (ifc)
    );

    ds_frame_parser #(.SYNC_WORD(16'hEB90), .ERR_CNT_W(2)) dut_sat (
        .sys_clk_i (clk),
        .rst_i     (rst),
        .ds_if     (ifc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         rst;
        logic         v;
        logic         s;
        logic         e;
        logic [31:0]  d;
        logic         ev;
        logic         es;
        logic         ee;
        logic [127:0] ed;
        logic         eerr;
        logic [7:0]   eid;
        logic [15:0]  ecnt;
    } vec_t;

    vec_t         vecs[$];
    logic [127:0] last_data;
    int           n_total;
    int           n_pass;

    function automatic logic [127:0] bd(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        return {a, b, c, d};
    endfunction

    task automatic add(input logic r, input logic v, input logic s, input logic e,
                       input logic [31:0] d, input logic ev, input logic es, input logic ee,
                       input logic [127:0] ed, input logic er, input logic [7:0] id,
                       input logic [15:0] cnt);
        vec_t x;
        if (r) last_data = '0;
        else if (ev) last_data = ed;
        x.rst = r; x.v = v; x.s = s; x.e = e; x.d = d;
        x.ev = ev; x.es = es; x.ee = ee; x.ed = last_data;
        x.eerr = er; x.eid = id; x.ecnt = cnt;
        vecs.push_back(x);
    endtask

    // Word or gap that produces no beat
    task automatic nb(input logic v, input logic s, input logic e, input logic [31:0] d,
                      input logic er, input logic [7:0] id, input logic [15:0] cnt);
        add(1'b0, v, s, e, d, 1'b0, 1'b0, 1'b0, '0, er, id, cnt);
    endtask

    // Payload word that completes a beat
    task automatic bt(input logic e, input logic [31:0] d, input logic es, input logic ee,
                      input logic [127:0] ed, input logic er, input logic [7:0] id,
                      input logic [15:0] cnt);
        add(1'b0, 1'b1, 1'b0, e, d, 1'b1, es, ee, ed, er, id, cnt);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        last_data = '0;
        rst = 1'b1;
        ifc.ds_word_valid_i = 1'b0; ifc.ds_word_sop_i = 1'b0;
        ifc.ds_word_eop_i = 1'b0;   ifc.ds_word_data_i = 32'h0;
        ifc2.ds_word_valid_i = 1'b0; ifc2.ds_word_sop_i = 1'b0;
        ifc2.ds_word_eop_i = 1'b0;   ifc2.ds_word_data_i = 32'h0;

        // reset state
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 8'h00, 16'd0);
        nb(0, 0, 0, 32'h0, 0, 8'h00, 0);
        nb(1, 0, 0, 32'hDEADBEEF, 0, 8'h00, 0);
        // good frame with gaps
        nb(1, 1, 0, 32'hEB902A02, 0, 8'h2A, 0);
        nb(1, 0, 0, 32'h0, 0, 8'h2A, 0);
        nb(1, 0, 0, 32'h1, 0, 8'h2A, 0);
        nb(0, 0, 0, 32'h0, 0, 8'h2A, 0);
        nb(1, 0, 0, 32'h2, 0, 8'h2A, 0);
        bt(0, 32'h3, 1, 0, bd(32'h0, 32'h1, 32'h2, 32'h3), 0, 8'h2A, 0);
        nb(1, 0, 0, 32'h4, 0, 8'h2A, 0);
        nb(0, 0, 0, 32'h0, 0, 8'h2A, 0);
        nb(1, 0, 0, 32'h5, 0, 8'h2A, 0);
        nb(1, 0, 0, 32'h6, 0, 8'h2A, 0);
        bt(1, 32'h7, 0, 1, bd(32'h4, 32'h5, 32'h6, 32'h7), 0, 8'h2A, 0);
        nb(0, 0, 0, 32'h0, 0, 8'h2A, 0);
        // bad sync
        nb(1, 1, 0, 32'hEB910501, 1, 8'h2A, 1);
        nb(1, 0, 0, 32'hA, 0, 8'h2A, 1);
        nb(1, 0, 0, 32'hB, 0, 8'h2A, 1);
        nb(1, 0, 0, 32'hC, 0, 8'h2A, 1);
        nb(1, 0, 1, 32'hD, 0, 8'h2A, 1);
        // short frame, then good single-beat frame
        nb(1, 1, 0, 32'hEB901102, 0, 8'h11, 1);
        nb(1, 0, 0, 32'h10, 0, 8'h11, 1);
        nb(1, 0, 0, 32'h11, 0, 8'h11, 1);
        nb(1, 0, 0, 32'h12, 0, 8'h11, 1);
        bt(0, 32'h13, 1, 0, bd(32'h10, 32'h11, 32'h12, 32'h13), 0, 8'h11, 1);
        nb(1, 0, 0, 32'h14, 0, 8'h11, 1);
        nb(1, 0, 1, 32'h15, 1, 8'h11, 2);
        nb(1, 1, 0, 32'hEB903301, 0, 8'h33, 2);
        nb(1, 0, 0, 32'h20, 0, 8'h33, 2);
        nb(1, 0, 0, 32'h21, 0, 8'h33, 2);
        nb(1, 0, 0, 32'h22, 0, 8'h33, 2);
        bt(1, 32'h23, 1, 1, bd(32'h20, 32'h21, 32'h22, 32'h23), 0, 8'h33, 2);
        // long frame
        nb(1, 1, 0, 32'hEB904401, 0, 8'h44, 2);
        nb(1, 0, 0, 32'h30, 0, 8'h44, 2);
        nb(1, 0, 0, 32'h31, 0, 8'h44, 2);
        nb(1, 0, 0, 32'h32, 0, 8'h44, 2);
        bt(0, 32'h33, 1, 1, bd(32'h30, 32'h31, 32'h32, 32'h33), 1, 8'h44, 3);
        nb(1, 0, 0, 32'h34, 0, 8'h44, 3);
        nb(1, 0, 1, 32'h35, 0, 8'h44, 3);
        // abort by a good header
        nb(1, 1, 0, 32'hEB905502, 0, 8'h55, 3);
        nb(1, 0, 0, 32'h40, 0, 8'h55, 3);
        nb(1, 0, 0, 32'h41, 0, 8'h55, 3);
        nb(1, 1, 0, 32'hEB907701, 1, 8'h77, 4);
        nb(1, 0, 0, 32'h50, 0, 8'h77, 4);
        nb(0, 0, 0, 32'h0, 0, 8'h77, 4);
        nb(1, 0, 0, 32'h51, 0, 8'h77, 4);
        nb(1, 0, 0, 32'h52, 0, 8'h77, 4);
        bt(1, 32'h53, 1, 1, bd(32'h50, 32'h51, 32'h52, 32'h53), 0, 8'h77, 4);
        // len=0 header, then header with eop
        nb(1, 1, 0, 32'hEB906600, 1, 8'h77, 5);
        nb(1, 0, 0, 32'h1234, 0, 8'h77, 5);
        nb(1, 0, 1, 32'h5678, 0, 8'h77, 5);
        nb(1, 1, 1, 32'hEB906601, 1, 8'h77, 6);
        nb(1, 0, 0, 32'h99, 0, 8'h77, 6);
        // abort by a bad header counts once
        nb(1, 1, 0, 32'hEB908801, 0, 8'h88, 6);
        nb(1, 0, 0, 32'h60, 0, 8'h88, 6);
        nb(1, 1, 0, 32'hEB910001, 1, 8'h88, 7);
        nb(1, 0, 0, 32'h61, 0, 8'h88, 7);
        nb(1, 0, 1, 32'h62, 0, 8'h88, 7);
        // header arriving while dropping
        nb(1, 1, 0, 32'hEB90BB01, 0, 8'hBB, 7);
        nb(1, 0, 0, 32'h70, 0, 8'hBB, 7);
        nb(1, 0, 0, 32'h71, 0, 8'hBB, 7);
        nb(1, 0, 0, 32'h72, 0, 8'hBB, 7);
        bt(0, 32'h73, 1, 1, bd(32'h70, 32'h71, 32'h72, 32'h73), 1, 8'hBB, 8);
        nb(1, 0, 0, 32'h74, 0, 8'hBB, 8);
        nb(1, 1, 0, 32'hEB90CC01, 0, 8'hCC, 8);
        nb(1, 0, 0, 32'h80, 0, 8'hCC, 8);
        nb(1, 0, 0, 32'h81, 0, 8'hCC, 8);
        nb(1, 0, 0, 32'h82, 0, 8'hCC, 8);
        bt(1, 32'h83, 1, 1, bd(32'h80, 32'h81, 32'h82, 32'h83), 0, 8'hCC, 8);
        // reset mid-frame, leftover words ignored
        nb(1, 1, 0, 32'hEB90DD02, 0, 8'hDD, 8);
        nb(1, 0, 0, 32'h90, 0, 8'hDD, 8);
        nb(1, 0, 0, 32'h91, 0, 8'hDD, 8);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h92, 1'b0, 1'b0, 1'b0, '0, 1'b0, 8'h00, 16'd0);
        nb(1, 0, 0, 32'h93, 0, 8'h00, 0);
        nb(1, 0, 1, 32'h94, 0, 8'h00, 0);
        nb(1, 1, 0, 32'hEB90EE01, 0, 8'hEE, 0);
        nb(1, 0, 0, 32'hA0, 0, 8'hEE, 0);
        nb(1, 0, 0, 32'hA1, 0, 8'hEE, 0);
        nb(1, 0, 0, 32'hA2, 0, 8'hEE, 0);
        bt(1, 32'hA3, 1, 1, bd(32'hA0, 32'hA1, 32'hA2, 32'hA3), 0, 8'hEE, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            ifc.ds_word_valid_i = vecs[i].v;
            ifc.ds_word_sop_i   = vecs[i].s;
            ifc.ds_word_eop_i   = vecs[i].e;
            ifc.ds_word_data_i  = vecs[i].d;
            @(posedge clk);
            #1;
            check($sformatf("row%0d valid", i), 128'(ifc.ds_burst_valid_o), 128'(vecs[i].ev));
            check($sformatf("row%0d sop", i),   128'(ifc.ds_burst_sop_o),   128'(vecs[i].es));
            check($sformatf("row%0d eop", i),   128'(ifc.ds_burst_eop_o),   128'(vecs[i].ee));
            check($sformatf("row%0d data", i),  ifc.ds_burst_data_o,        vecs[i].ed);
            check($sformatf("row%0d err", i),   128'(ifc.frame_err_o),      128'(vecs[i].eerr));
            check($sformatf("row%0d des_id", i), 128'(ifc.prased_des_id_o), 128'(vecs[i].eid));
            check($sformatf("row%0d err_cnt", i), 128'(ifc.frame_err_cnt_o), 128'(vecs[i].ecnt));
        end
        rst = 1'b0;
        ifc.ds_word_valid_i = 1'b0;
        ifc.ds_word_sop_i   = 1'b0;
        ifc.ds_word_eop_i   = 1'b0;

        // 2-bit counter saturates at 3 while each bad header still pulses
        for (int k = 0; k < 5; k++) begin
            ifc2.ds_word_valid_i = 1'b1;
            ifc2.ds_word_sop_i   = 1'b1;
            ifc2.ds_word_eop_i   = 1'b1;
            ifc2.ds_word_data_i  = 32'hEB910501;
            @(posedge clk);
            #1;
            check($sformatf("sat%0d err", k), 128'(ifc2.frame_err_o), 128'(1));
            check($sformatf("sat%0d err_cnt", k), 128'(ifc2.frame_err_cnt_o),
                  128'((k < 3) ? k + 1 : 3));
        end
        ifc2.ds_word_valid_i = 1'b0;
        ifc2.ds_word_sop_i   = 1'b0;
        ifc2.ds_word_eop_i   = 1'b0;
        @(posedge clk);
        #1;
        check("sat idle err", 128'(ifc2.frame_err_o), 128'(0));
        check("sat idle err_cnt", 128'(ifc2.frame_err_cnt_o), 128'(3));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
